// File: rtl/add_round_key_iter.sv
// Iterative AddRoundKey: XORs a captured state block with its round key one
// LANE_W-bit lane per cycle, MSB lane first, and holds the result until consumed.
module add_round_key_iter #(
    parameter int BLOCK_W = 128,
    parameter int LANE_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_word,
    input  logic [BLOCK_W-1:0] in_key,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_str,
    output logic               busy
);

    localparam int NLANE = BLOCK_W / LANE_W;
    localparam int CW    = (NLANE > 1) ? $clog2(NLANE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BLOCK_W-1:0]   word_q, word_d;
    logic [BLOCK_W-1:0]   key_q, key_d;
    logic                 bypass_q, bypass_d;
    logic [BLOCK_W-1:0]   res_q, res_d;

    // in_ready is masked by rst so nothing is accepted on a reset edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_str   = res_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        key_d    = key_q;
        bypass_d = bypass_q;
        res_d    = res_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d   = in_word;
                    key_d    = in_key;
                    bypass_d = in_bypass;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Only the lane selected by cnt_q is rewritten; the loop builds one shared XOR slice mux.
                for (int unsigned i = 0; i < NLANE; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[BLOCK_W-1-i*LANE_W -: LANE_W] =
                            word_q[BLOCK_W-1-i*LANE_W -: LANE_W] ^
                            ({LANE_W{~bypass_q}} & key_q[BLOCK_W-1-i*LANE_W -: LANE_W]);
                    end
                end
                if (cnt_q == CW'(NLANE - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            key_q    <= '0;
            bypass_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            key_q    <= key_d;
            bypass_q <= bypass_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_add_round_key_iter.sv
// Directed bench: five engines (LANE_W 8..128) share one input stream; each
// is checked for result, latency, valid pulse width, backpressure and reset.
module tb_add_round_key_iter;

    localparam int NDUT = 5;

    localparam logic [127:0] FIPS_W   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] SEQ_W    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ_K    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R    = 128'h00102030405060708090a0b0c0d0e0f0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_word;
    logic [127:0] in_key;
    logic         in_bypass;
    logic         out_ready;

    logic [NDUT-1:0] in_ready_v;
    logic [NDUT-1:0] out_valid_v;
    logic [NDUT-1:0] busy_v;
    logic [127:0]    out_str_v [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        add_round_key_iter #(
            .BLOCK_W(128),
            .LANE_W (8 << g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready_v[g]),
            .in_word  (in_word),
            .in_key   (in_key),
            .in_bypass(in_bypass),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready),
            .out_str  (out_str_v[g]),
            .busy     (busy_v[g])
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one block into all engines with out_ready high; checks result, latency and pulse width.
    task automatic run_block(input logic [127:0] w, input logic [127:0] k, input logic byp,
                             input logic [127:0] exp, input logic perturb, input string tag);
        int lat  [NDUT];
        int vcnt [NDUT];
        for (int g = 0; g < NDUT; g++) begin
            lat[g]  = -1;
            vcnt[g] = 0;
        end
        in_word   = w;
        in_key    = k;
        in_bypass = byp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq({tag, " in_ready before accept"}, 128'(in_ready_v), 128'h1f);
        tick();
        in_valid = 1'b0;
        check_eq({tag, " busy after accept"}, 128'(busy_v), 128'h1f);
        for (int c = 1; c <= 20; c++) begin
            if (perturb) begin
                in_word   = {$urandom, $urandom, $urandom, $urandom};
                in_key    = {$urandom, $urandom, $urandom, $urandom};
                in_bypass = 1'($urandom_range(0, 1));
            end
            tick();
            for (int g = 0; g < NDUT; g++) begin
                if (out_valid_v[g]) begin
                    vcnt[g]++;
                    if (lat[g] < 0) begin
                        lat[g] = c;
                        check_eq($sformatf("%s out_str lane%0d", tag, 8 << g), out_str_v[g], exp);
                    end
                end
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("%s latency lane%0d", tag, 8 << g), 128'(lat[g]), 128'(16 >> g));
            check_eq($sformatf("%s valid cycles lane%0d", tag, 8 << g), 128'(vcnt[g]), 128'd1);
            check_eq($sformatf("%s out_str held lane%0d", tag, 8 << g), out_str_v[g], exp);
        end
        check_eq({tag, " busy idle"}, 128'(busy_v), 128'h0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_key    = '0;
        in_bypass = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("reset in_ready", 128'(in_ready_v), 128'h0);
        check_eq("reset out_valid", 128'(out_valid_v), 128'h0);
        check_eq("reset busy", 128'(busy_v), 128'h0);
        for (int g = 0; g < NDUT; g++)
            check_eq($sformatf("reset out_str lane%0d", 8 << g), out_str_v[g], 128'h0);
        rst = 1'b0;
        #1;
        check_eq("in_ready after reset", 128'(in_ready_v), 128'h1f);

        // FIPS-197 round 0 at every lane width
        run_block(FIPS_W, FIPS_K, 1'b0, FIPS_R, 1'b0, "fips");

        // Bypass ignores the key
        run_block(SEQ_W, 128'hdeadbeefcafef00d0123456789abcdef, 1'b1, SEQ_W, 1'b0, "bypass");

        // Plain XOR on a second pattern
        run_block(SEQ_W, SEQ_K, 1'b0, SEQ_R, 1'b0, "seq");

        // Backpressure with a second block waiting on in_valid
        in_word   = FIPS_W;
        in_key    = FIPS_K;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_word = SEQ_W;
        in_key  = SEQ_K;
        for (int c = 0; c < 20 && out_valid_v != 5'h1f; c++) tick();
        check_eq("bp all done", 128'(out_valid_v), 128'h1f);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("bp out_str stable", out_str_v[2], FIPS_R);
            check_eq("bp in_ready low", 128'(in_ready_v[2]), 128'h0);
            check_eq("bp out_valid held", 128'(out_valid_v[2]), 128'h1);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp idle after handshake", 128'({busy_v[2], in_ready_v[2]}), 128'b01);
        tick();
        in_valid = 1'b0;
        check_eq("bp second accepted", 128'({busy_v[2], in_ready_v[2]}), 128'b10);
        for (int c = 1; c <= 4; c++) begin
            check_eq("bp second not early", 128'(out_valid_v[2]), 128'h0);
            tick();
        end
        check_eq("bp second valid", 128'(out_valid_v[2]), 128'h1);
        check_eq("bp second out_str", out_str_v[2], SEQ_R);
        for (int c = 0; c < 20 && busy_v != 5'h0; c++) tick();
        check_eq("bp drained", 128'(busy_v), 128'h0);
        check_eq("bp lane8 second out_str", out_str_v[0], SEQ_R);

        // Mid-RUN reset, five cycles after accept
        in_word   = FIPS_W;
        in_key    = FIPS_K;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check_eq("mid-run lane8 busy", 128'(busy_v[0]), 128'h1);
        rst = 1'b1;
        tick();
        check_eq("mid-run rst in_ready", 128'(in_ready_v), 128'h0);
        check_eq("mid-run rst out_valid", 128'(out_valid_v), 128'h0);
        check_eq("mid-run rst busy", 128'(busy_v), 128'h0);
        check_eq("mid-run rst out_str lane8", out_str_v[0], 128'h0);
        check_eq("mid-run rst out_str lane128", out_str_v[4], 128'h0);
        rst = 1'b0;
        #1;
        check_eq("mid-run in_ready after rst", 128'(in_ready_v), 128'h1f);
        run_block(FIPS_W, FIPS_K, 1'b0, FIPS_R, 1'b0, "post-rst");

        // Inputs perturbed every cycle during RUN
        run_block(FIPS_W, FIPS_K, 1'b0, FIPS_R, 1'b1, "perturb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_round_key_iter.md
# add_round_key_iter

Parametrised, iterative AddRoundKey engine for the AES datapath. It accepts one state block and one round key over a valid/ready handshake. It XORs them LANE_W bits per cycle, starting from the most-significant lane, so one XOR slice can be shared across the block. It presents the result on a valid/ready output and serves as the area-scalable successor to the fully combinational 128-bit AddRoundKey, with lane width selectable from byte-serial to full-parallel.

## Interface
- BLOCK_W, 128: state/key width in bits; must be a multiple of LANE_W.
- LANE_W, 32: bits XORed per cycle; legal values 8, 16, 32, 64, 128 (for BLOCK_W=128).
- NLANE (derived, not overridable): BLOCK_W/LANE_W.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word/key/bypass valid.
- in_ready  out  1  engine can accept a block.
- in_word  in  BLOCK_W  state block.
- in_key  in  BLOCK_W  round key.
- in_bypass  in  1  1 = pass in_word through unmodified (key ignored).
- out_valid  out  1  out_str holds a finished result.
- out_ready  in  1  downstream accepts result.
- out_str  out  BLOCK_W  result block.
- busy  out  1  high in RUN or DONE.

## Operation
- Lane i (i = 0..NLANE-1) is bits [BLOCK_W-1-i*LANE_W -: LANE_W]. Lane 0 is the MSB lane, matching {s0,s1,s2,s3} word order.
- Reset: state IDLE, lane counter 0, out_valid 0, out_str 0, busy 0, internal word/key/bypass registers 0; in_ready 0 while rst is high.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_word, in_key and in_bypass into internal registers, clear the lane counter, and go to RUN.
  - RUN: each cycle, write lane[cnt] of the result register = word lane ^ (bypass ? 0 : key lane), then increment cnt. When cnt==NLANE-1, write the last lane and go to DONE.
  - DONE: out_valid=1 and out_str stable. On out_ready, go to IDLE.
- in_ready is low in RUN and DONE. A block is never accepted in the same cycle a result is consumed; the earliest next accept is the cycle after the return to IDLE.
- The lane counter width is max(1, clog2(NLANE)). The counter never wraps past NLANE-1; it is cleared on accept.
- Input ports are sampled only on the accept edge. Changes to in_word/in_key/in_bypass during RUN have no effect.
- out_str holds its last result after the DONE→IDLE transition until the next block's lanes overwrite it. Consumers must use it only when out_valid=1.
- rst asserted in any state (including mid-RUN or DONE with out_valid=1) returns to the reset state on that edge. The partial or pending result is discarded and out_valid drops the next cycle.
- in_valid in RUN/DONE is ignored and does not need to be held stable by the engine; the upstream holds it per standard valid/ready rules.
- busy = (state != IDLE).

## Timing
- Accept at edge t.
- RUN occupies edges t+1..t+NLANE.
- out_valid rises after edge t+NLANE, so latency is NLANE cycles from accept to out_valid.
- With out_ready held high, DONE lasts 1 cycle, IDLE 1 cycle, and the next accept occurs one cycle after return to IDLE. The throughput period is NLANE+2 cycles per block.
- With LANE_W=BLOCK_W, NLANE=1: latency 1 cycle, period 3 cycles.
- Backpressure: out_valid and out_str stay constant for as long as out_ready=0. There is no timeout.
- No combinational path from in_* to out_*. in_ready depends only on state and rst.

## Test plan
- FIPS-197 round 0, LANE_W=32: in_word=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1. Required: out_str=193de3bea0f4e22b9ac68d2ae9f84808, out_valid high exactly 4 cycles after accept, for 1 cycle.
- Same vector at LANE_W=8, 16, 64 and 128. Required: identical out_str, with latency 16, 8, 2 and 1 cycles respectively.
- Bypass: in_bypass=1, in_word=00112233445566778899aabbccddeeff, any key. Required: out_str=00112233445566778899aabbccddeeff.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid held high carrying a second block. Required: out_str stable and in_ready=0 throughout. The second block is accepted the cycle after the handshake-plus-IDLE and produces its correct result.
- Mid-RUN reset, LANE_W=8: assert rst 5 cycles after accept. Required: the next cycle shows out_valid=0, busy=0, out_str=0. in_ready rises the cycle after rst deasserts, and a fresh FIPS-197 vector then completes correctly.
- Input perturbation: change in_word/in_key every cycle during RUN. Required: the result equals the XOR of the values captured at accept.
